dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Requester side of the processor's data-memory interface. Accepts one memory operation per instruction from the execute stage, decodes it into a read or write request, and drives it over a req/ack handshake to a multi-cycle data memory. Returns valM and dmem_error to the processor with a one-cycle done pulse, and holds busy high so the sequencer stalls until completion.

## Interface

Parameters:
- ADDR_MAX, 255: highest legal word address. Any address above it is an error.
- TIMEOUT, 15: maximum number of cycles spent in REQ waiting for mem_ack before aborting.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request valid from execute. Sampled only in IDLE.
- icode  in  4  instruction code.
- valA  in  64  register operand A.
- valE  in  64  ALU result.
- valP  in  64  next-PC value.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- valM  out  64  read data. Holds its last value between reads.
- dmem_error  out  1  error flag. Valid while done is high, and held until the next accepted start.
- mem_req  out  1  request to memory.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req is high.
- mem_addr  out  64  word address. Valid while mem_req is high.
- mem_wdata  out  64  write data. Valid while mem_req is high.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  64  read data. Valid in the cycle mem_ack is high.

## Operation

Decode (latched at start):
- 4 rmmovq: write valA to valE.
- 5 mrmovq: read from valE.
- 8 call: write valP to valE.
- 9 ret: read from valA.
- A pushq: write valA to valE.
- B popq: read from valA.
- Any other icode: no access.

Address check: the unsigned address must be ≤ ADDR_MAX, otherwise dmem_error.

FSM states are IDLE, REQ and DONE.
- IDLE, start=1, memory icode, address legal: go to REQ. Register mem_we, mem_addr and mem_wdata, clear dmem_error, clear the timeout counter.
- IDLE, start=1, non-memory icode: go to DONE with dmem_error=0. No request is issued.
- IDLE, start=1, illegal address: go to DONE with dmem_error=1. No request is issued.
- REQ, mem_ack=1: go to DONE. For a read, valM ← mem_rdata.
- REQ, no ack, counter = TIMEOUT−1: go to DONE with dmem_error=1. The request is abandoned and valM is unchanged.
- REQ otherwise: counter increments.
- DONE: go to IDLE unconditionally.

Output rules:
- mem_req = (state==REQ). mem_addr, mem_we and mem_wdata are stable for the whole REQ interval.
- done = (state==DONE).
- start while busy is ignored and not queued.
- mem_ack outside REQ is ignored.

## Timing

- Reset: state=IDLE. busy, done, mem_req, mem_we and dmem_error = 0. mem_addr, mem_wdata and valM = 0. Counter = 0.
- Reset while in REQ: mem_req drops at the reset edge and no done is produced.
- Reset has priority over every other event.
- start accepted at edge T. With ack arriving k cycles after mem_req rises (k≥0 cycles of wait), mem_req is high from T+1 through T+1+k, and done is high in cycle T+2+k.
- Minimum access latency is start to done in 2 cycles.
- No-access or illegal-address operation: done is high in cycle T+1. mem_req never rises.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then done=1 with dmem_error=1.
- ack in the final counted cycle: ack wins and there is no error.
- busy is high from T+1 through the done cycle inclusive. A new start is accepted in the cycle after done at the earliest.
- valM updates on the edge entering DONE, so it is valid in the same cycle as done.

## Test plan

1. Reset, then start with icode=4, valE=0x10, valA=0xDEAD, and ack after 2 wait cycles.
   - Required: mem_req high for 3 cycles with mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD.
   - Required: done in cycle T+4, dmem_error=0.
2. icode=B, valA=0x10, ack immediately with mem_rdata=0xDEAD.
   - Required: mem_we=0, mem_addr=0x10.
   - Required: done at T+2 with valM=0xDEAD.
3. icode=8, valE=0x100, ADDR_MAX=255.
   - Required: no mem_req, done at T+1, dmem_error=1, valM unchanged.
4. icode=5 with no ack ever.
   - Required: mem_req high for exactly 15 cycles, then done with dmem_error=1.
   - Repeat with ack in the 15th cycle. Required: no error, valM captured.
5. icode=6 (OPq).
   - Required: done at T+1, dmem_error=0, no mem_req.
   - Required: start pulses asserted while busy produce no extra done.
6. Assert rst in the second REQ cycle.
   - Required: all outputs are 0 next cycle and no done.
   - Required: a following start works normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: requester side of the data-memory port.
// Decodes one memory op per start and runs a req/ack handshake with timeout.
module dmem_access_ctrl #(
    parameter logic [63:0] ADDR_MAX = 64'd255,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;

    logic          dec_mem;
    logic          dec_we;
    logic [63:0]   dec_addr;
    logic [63:0]   dec_wdata;
    logic          addr_ok;
    logic          go_req;
    logic          last_cnt;

    // Decode the instruction into access kind, address and write data
    always_comb begin
        dec_mem   = 1'b0;
        dec_we    = 1'b0;
        dec_addr  = valE;
        dec_wdata = valA;
        case (icode)
            4'h4: begin
                dec_mem = 1'b1;
                dec_we  = 1'b1;
            end
            4'h5: dec_mem = 1'b1;
            4'h8: begin
                dec_mem   = 1'b1;
                dec_we    = 1'b1;
                dec_wdata = valP;
            end
            4'h9: begin
                dec_mem  = 1'b1;
                dec_addr = valA;
            end
            4'hA: begin
                dec_mem = 1'b1;
                dec_we  = 1'b1;
            end
            4'hB: begin
                dec_mem  = 1'b1;
                dec_addr = valA;
            end
            default: ;
        endcase
    end

    assign addr_ok  = (dec_addr <= ADDR_MAX);
    assign go_req   = dec_mem && addr_ok;
    assign last_cnt = (cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; ack in the last counted cycle still completes cleanly
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) state_n = go_req ? REQ : DONE;
            end
            REQ: begin
                if (mem_ack || last_cnt) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields, wait counter, read data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            valM       <= '0;
            dmem_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_error <= dec_mem && !addr_ok;
                        if (go_req) begin
                            mem_we    <= dec_we;
                            mem_addr  <= dec_addr;
                            mem_wdata <= dec_wdata;
                            cnt       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) valM <= mem_rdata;
                    end else if (last_cnt) begin
                        dmem_error <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign mem_req = (state == REQ);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and random ops checked
// against a transaction-level model of the memory requester.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic        dmem_error;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] m_valm = 64'd0;

    dmem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .busy       (busy),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation; k = wait cycles before ack (-1 = never ack)
    task automatic run_op(input logic [3:0] ic, input logic [63:0] a,
                          input logic [63:0] e, input logic [63:0] p,
                          input int k, input logic [63:0] rd);
        logic        mem;
        logic        we;
        logic [63:0] ad;
        logic [63:0] wd;
        logic        err;
        int          exp_req;
        int          exp_done;
        logic [63:0] exp_valm;
        int          nreq;
        int          bad;
        int          got_done;

        mem = 1'b0;
        we  = 1'b0;
        ad  = e;
        wd  = a;
        case (ic)
            4'h4: begin mem = 1'b1; we = 1'b1; end
            4'h5: mem = 1'b1;
            4'h8: begin mem = 1'b1; we = 1'b1; wd = p; end
            4'h9: begin mem = 1'b1; ad = a; end
            4'hA: begin mem = 1'b1; we = 1'b1; end
            4'hB: begin mem = 1'b1; ad = a; end
            default: ;
        endcase
        err      = 1'b0;
        exp_valm = m_valm;
        if (!mem) begin
            exp_req  = 0;
            exp_done = 1;
        end else if (ad > 64'd255) begin
            err      = 1'b1;
            exp_req  = 0;
            exp_done = 1;
        end else if (k >= 0 && k < 15) begin
            exp_req  = k + 1;
            exp_done = k + 2;
            if (!we) exp_valm = rd;
        end else begin
            exp_req  = 15;
            exp_done = 16;
            err      = 1'b1;
        end

        @(negedge clk);
        start   = 1'b1;
        icode   = ic;
        valA    = a;
        valE    = e;
        valP    = p;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        nreq     = 0;
        bad      = 0;
        got_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!busy) bad++;
            if (mem_req) begin
                nreq++;
                if (mem_we !== we || mem_addr !== ad || mem_wdata !== wd)
                    bad++;
            end
            mem_rdata = {$urandom, $urandom};
            if (done) begin
                got_done = n;
                mem_ack  = 1'($urandom % 2);
                start    = 1'b0;
                break;
            end
            if (mem_req) begin
                mem_ack = (nreq - 1 == k);
                if (mem_ack) mem_rdata = rd;
            end else begin
                mem_ack = 1'($urandom % 2);
            end
            start = 1'($urandom % 2);
            icode = 4'($urandom);
            valA  = {$urandom, $urandom};
            valE  = {$urandom, $urandom};
            valP  = {$urandom, $urandom};
        end
        if (got_done == 0) chk("done_timeout", 64'd0, 64'd1);
        chk("done_cycle", 64'(got_done), 64'(exp_done));
        chk("req_cycles", 64'(nreq), 64'(exp_req));
        chk("req_fields_busy", 64'(bad), 64'd0);
        chk("dmem_error", 64'(dmem_error), 64'(err));
        chk("valM", valM, exp_valm);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_after", 64'({done, busy, mem_req}), 64'd0);
        chk("err_hold", 64'(dmem_error), 64'(err));
        m_valm = exp_valm;
    endtask

    // Reset asserted during the second REQ cycle
    task automatic reset_in_req();
        int bad;
        @(negedge clk);
        start   = 1'b1;
        icode   = 4'h5;
        valE    = 64'h20;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_req1", 64'(mem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", 64'({busy, done, mem_req, mem_we, dmem_error}), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_valM", valM, 64'd0);
        rst    = 1'b0;
        m_valm = 64'd0;
        bad    = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done || busy || mem_req) bad++;
        end
        chk("rst_no_done", 64'(bad), 64'd0);
    endtask

    initial begin
        logic [3:0] ic;
        logic [3:0] pick [8];
        pick = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h0};
        rst       = 1'b1;
        start     = 1'b0;
        icode     = 4'h0;
        valA      = '0;
        valE      = '0;
        valP      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, mem_req, mem_we, dmem_error}), 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_valM", valM, 64'd0);
        rst = 1'b0;

        run_op(4'h4, 64'hDEAD, 64'h10, 64'h0, 2, 64'h0);
        run_op(4'hB, 64'h10, 64'h0, 64'h0, 0, 64'hDEAD);
        run_op(4'h8, 64'h0, 64'h100, 64'h55, 0, 64'h0);
        run_op(4'h5, 64'h0, 64'h20, 64'h0, -1, 64'h1234);
        run_op(4'h5, 64'h0, 64'h21, 64'h0, 14, 64'hBEEF);
        run_op(4'h6, 64'h0, 64'h21, 64'h0, 0, 64'h0);
        run_op(4'h9, 64'h0, 64'h0, 64'h0, 3, 64'hCAFE);
        run_op(4'hA, 64'h7, 64'hFF, 64'h0, 1, 64'h0);
        reset_in_req();
        run_op(4'h5, 64'h0, 64'h30, 64'h0, 1, 64'h77);

        for (int i = 0; i < 40; i++) begin
            ic = ($urandom % 4 == 0) ? 4'($urandom) : pick[$urandom % 8];
            run_op(ic, 64'($urandom_range(0, 300)), 64'($urandom_range(0, 300)),
                   {$urandom, $urandom}, int'($urandom_range(0, 17)) - 1,
                   {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
